// File: rtl/fp_pkg.sv
// Shared constants and types for the pipelined floating-point add/subtract unit.
package fp_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    // Bit positions within the 5-bit flags vector {NV, DZ, OF, UF, NX}
    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUB,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
        return 1 + exp_w + man_w;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Parametrised leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
    parameter  int unsigned WIDTH = 27,
    localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Ascending scan: the highest set bit is the last one to write the count
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) count_o = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/subtract with valid/ready handshake and global stall.
// Define FP_ADDSUB_FTZ_EN to flush subnormal inputs and results to signed zero.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = fp_width(EXP_W, MAN_W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         op_sub,
    input  logic [1:0]   round_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [4:0]   flags
);

    localparam int unsigned SW = MAN_W + 4;           // hidden + fraction + G/R/S
    localparam int unsigned EW = EXP_W + 1;
    localparam int unsigned LW = $clog2(SW + 1);
    localparam int unsigned NW = (EW > LW) ? EW : LW;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_MAX - EXP_W'(1);
    localparam logic [W-1:0] QNAN = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic fp_class_e classify(input logic [W-1:0] x);
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] f;
        e = x[W-2 -: EXP_W];
        f = x[MAN_W-1:0];
        if (e == '0)           return (f == '0) ? CLS_ZERO : CLS_SUB;
        else if (e == EXP_MAX) return (f == '0) ? CLS_INF : (f[MAN_W-1] ? CLS_QNAN : CLS_SNAN);
        else                   return CLS_NORM;
    endfunction

    logic v1_q, v2_q, out_valid_q;
    logic spec1_q, nv1_q, sign1_q, effsub1_q;
    logic [W-1:0] specres1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [SW-1:0] big1_q, sml1_q;
    logic [1:0] rm1_q;
    logic spec2_q, nv2_q, sign2_q;
    logic [W-1:0] specres2_q;
    logic [EW-1:0] exp2_q;
    logic [SW-1:0] sig2_q;
    logic [1:0] rm2_q;
    logic [W-1:0] result_q;
    logic [4:0] flags_q;

    assign in_ready  = !(out_valid_q && !out_ready);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // S1: classify, resolve specials, order by magnitude and align the smaller operand
    fp_class_e cls_a, cls_b;
    logic sa, sb, swap, s_big;
    logic [EXP_W-1:0] ea, eb, e_big, e_dif;
    logic [MAN_W:0] ma, mb, m_big, m_sml;
    logic [LW-1:0] sh;
    logic [SW-1:0] sml_ext, sml_mask, sml_shf, sml_d;
    logic spec_d, nv_d;
    logic [W-1:0] specres_d;

    always_comb begin
        cls_a = classify(op_a);
        cls_b = classify(op_b);
`ifdef FP_ADDSUB_FTZ_EN
        if (cls_a == CLS_SUB) cls_a = CLS_ZERO;
        if (cls_b == CLS_SUB) cls_b = CLS_ZERO;
`endif
        sa = op_a[W-1];
        sb = op_b[W-1] ^ op_sub;
        ea = (op_a[W-2 -: EXP_W] == '0) ? EXP_W'(1) : op_a[W-2 -: EXP_W];
        eb = (op_b[W-2 -: EXP_W] == '0) ? EXP_W'(1) : op_b[W-2 -: EXP_W];
        ma = (cls_a == CLS_ZERO) ? '0 : {op_a[W-2 -: EXP_W] != '0, op_a[MAN_W-1:0]};
        mb = (cls_b == CLS_ZERO) ? '0 : {op_b[W-2 -: EXP_W] != '0, op_b[MAN_W-1:0]};
        swap  = {eb, mb} > {ea, ma};
        s_big = swap ? sb : sa;
        e_big = swap ? eb : ea;
        m_big = swap ? mb : ma;
        m_sml = swap ? ma : mb;
        e_dif = e_big - (swap ? ea : eb);
        sh       = (32'(e_dif) > SW - 1) ? LW'(SW - 1) : LW'(e_dif);
        sml_ext  = {m_sml, 3'b000};
        sml_mask = ~({SW{1'b1}} << sh);
        sml_shf  = sml_ext >> sh;
        sml_d    = {sml_shf[SW-1:1], sml_shf[0] | (|(sml_ext & sml_mask))};

        spec_d    = 1'b0;
        nv_d      = 1'b0;
        specres_d = '0;
        if (cls_a inside {CLS_QNAN, CLS_SNAN} || cls_b inside {CLS_QNAN, CLS_SNAN}) begin
            spec_d    = 1'b1;
            specres_d = QNAN;
            nv_d      = (cls_a == CLS_SNAN) || (cls_b == CLS_SNAN);
        end else if (cls_a == CLS_INF && cls_b == CLS_INF) begin
            spec_d    = 1'b1;
            specres_d = (sa != sb) ? QNAN : {sa, EXP_MAX, {MAN_W{1'b0}}};
            nv_d      = (sa != sb);
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            spec_d    = 1'b1;
            specres_d = {(cls_a == CLS_INF) ? sa : sb, EXP_MAX, {MAN_W{1'b0}}};
        end
    end

    // S2: magnitude add/subtract and normalise, never below exponent 1
    logic [SW:0] sum;
    logic [LW-1:0] lz;
    logic [NW-1:0] lim, shl;
    logic [SW-1:0] norm_d;
    logic [EW-1:0] nexp_d;
    logic sign2_d;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .data_i  (sum[SW-1:0]),
        .count_o (lz)
    );

    always_comb begin
        sum = effsub1_q ? ({1'b0, big1_q} - {1'b0, sml1_q}) : ({1'b0, big1_q} + {1'b0, sml1_q});
        lim = NW'(exp1_q) - NW'(1);
        shl = (NW'(lz) < lim) ? NW'(lz) : lim;
        if (sum[SW]) begin
            norm_d = {sum[SW:2], sum[1] | sum[0]};
            nexp_d = EW'(exp1_q) + EW'(1);
        end else begin
            norm_d = sum[SW-1:0] << shl;
            nexp_d = EW'(exp1_q) - EW'(shl);
        end
        sign2_d = sign1_q;
        if (sum == '0 && effsub1_q) sign2_d = (rm1_q == RM_RDN);
    end

    // S3: round, detect overflow/underflow, pack
    logic nx, up, hid, ovf, to_inf;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W-1:0] frac;
    logic [EW-1:0] fexp;
    logic [W-1:0] res_d;
    logic [4:0] flg_d;

    always_comb begin
        res_d = '0;
        flg_d = '0;
        nx    = |sig2_q[2:0];
        case (rm2_q)
            RM_RNE:  up = sig2_q[2] & ((|sig2_q[1:0]) | sig2_q[3]);
            RM_RUP:  up = nx & !sign2_q;
            RM_RDN:  up = nx & sign2_q;
            default: up = 1'b0;
        endcase
        rnd = {1'b0, sig2_q[SW-1:3]} + (MAN_W+2)'(up);
        if (rnd[MAN_W+1]) begin
            fexp = exp2_q + EW'(1);
            frac = '0;
            hid  = 1'b1;
        end else begin
            fexp = exp2_q;
            frac = rnd[MAN_W-1:0];
            hid  = rnd[MAN_W];
        end
        ovf    = fexp >= EW'(EXP_MAX);
        to_inf = (rm2_q == RM_RNE) || (rm2_q == RM_RUP && !sign2_q) || (rm2_q == RM_RDN && sign2_q);
        res_d  = {sign2_q, (hid ? fexp[EXP_W-1:0] : {EXP_W{1'b0}}), frac};
        if (spec2_q) begin
            res_d         = specres2_q;
            flg_d[FLG_NV] = nv2_q;
        end else if (ovf) begin
            flg_d[FLG_OF] = 1'b1;
            flg_d[FLG_NX] = 1'b1;
            res_d = to_inf ? {sign2_q, EXP_MAX, {MAN_W{1'b0}}} : {sign2_q, EXP_TOP, {MAN_W{1'b1}}};
        end else begin
            flg_d[FLG_NX] = nx;
            if (!hid) begin
`ifdef FP_ADDSUB_FTZ_EN
                if (nx || frac != '0) begin
                    res_d         = {sign2_q, {(W-1){1'b0}}};
                    flg_d[FLG_UF] = 1'b1;
                    flg_d[FLG_NX] = 1'b1;
                end
`else
                flg_d[FLG_UF] = nx;
`endif
            end
        end
    end

    // Pipeline registers; everything holds while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; out_valid_q <= 1'b0;
            spec1_q <= 1'b0; nv1_q <= 1'b0; sign1_q <= 1'b0; effsub1_q <= 1'b0;
            specres1_q <= '0; exp1_q <= '0; big1_q <= '0; sml1_q <= '0; rm1_q <= '0;
            spec2_q <= 1'b0; nv2_q <= 1'b0; sign2_q <= 1'b0;
            specres2_q <= '0; exp2_q <= '0; sig2_q <= '0; rm2_q <= '0;
            result_q <= '0; flags_q <= '0;
        end else if (in_ready) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (in_valid) begin
                spec1_q <= spec_d; nv1_q <= nv_d; specres1_q <= specres_d;
                sign1_q <= s_big; effsub1_q <= sa ^ sb; exp1_q <= e_big;
                big1_q <= {m_big, 3'b000}; sml1_q <= sml_d; rm1_q <= round_mode;
            end
            if (v1_q) begin
                spec2_q <= spec1_q; nv2_q <= nv1_q; specres2_q <= specres1_q;
                sign2_q <= sign2_d; exp2_q <= nexp_d; sig2_q <= norm_d; rm2_q <= rm1_q;
            end
            if (v2_q) begin
                result_q <= res_d;
                flags_q  <= flg_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (single precision): vectors, streaming with stalls, reset.
module tb_fp_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
    logic [31:0] op_a, op_b, result;
    logic [1:0]  round_mode;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NV = 18;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    logic [31:0] vr [NV];
    logic        vs [NV];
    logic [1:0]  vm [NV];
    logic [4:0]  vf [NV];

    int acc, got, cyc, first_acc, first_ov;
    logic held_v;
    logic [31:0] held_res;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .round_mode (round_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int k);
        op_a = va[k]; op_b = vb[k]; op_sub = vs[k]; round_mode = vm[k];
    endtask

    // One isolated operation: checks acceptance, 3-cycle latency, result and flags
    task automatic run_op(input int k);
        int n;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1; drive(k);
        #1 chk($sformatf("in_ready_v%0d", k), 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency_v%0d", k), 32'(n), 32'd3);
        chk($sformatf("result_v%0d", k), result, vr[k]);
        chk($sformatf("flags_v%0d", k), 32'(flags), 32'(vf[k]));
        @(negedge clk);
    endtask

    initial begin
        va = '{32'h41A60000, 32'h41020000, 32'h7F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000,
               32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000002, 32'h3F800000, 32'h3F800000, 32'h7FA00000,
               32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h80000000, 32'h3F800000};
        vb = '{32'h40100000, 32'h41040000, 32'hFF800000, 32'h7F800000, 32'h33800000, 32'h33800000,
               32'h7F7FFFFF, 32'h7F7FFFFF, 32'h00000002, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h00000001, 32'h3F800000, 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h80000000, 32'hBF800000};
        vs = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vm = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd3, 2'd0,
               2'd0, 2'd0, 2'd3, 2'd3, 2'd0, 2'd3};
        vr = '{32'h41B80000, 32'hBE000000, 32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h3F800001,
               32'h7F800000, 32'h7F7FFFFF, 32'h00000004, 32'h00000000, 32'h80000000, 32'h7FC00000,
               32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h80000000, 32'h80000000};
        vf = '{5'h00, 5'h00, 5'h10, 5'h00, 5'h01, 5'h01, 5'h05, 5'h05, 5'h00, 5'h00, 5'h00, 5'h10,
               5'h00, 5'h00, 5'h05, 5'h05, 5'h00, 5'h00};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; op_sub = 1'b0; round_mode = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int k = 0; k < NV; k++) run_op(k);

        // Stream of 8 beats with out_ready cycling 1,0,0
        acc = 0; got = 0; cyc = 0; first_acc = -1; first_ov = -1; held_v = 1'b0; held_res = '0;
        while (got < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 3 == 0);
            in_valid  = (acc < 8);
            if (acc < 8) drive(acc);
            #1;
            if (held_v) begin
                chk($sformatf("stall_valid_c%0d", cyc), 32'(out_valid), 32'd1);
                chk($sformatf("stall_hold_c%0d", cyc), result, held_res);
            end
            if (out_valid && first_ov < 0) first_ov = cyc;
            if (out_valid && out_ready) begin
                chk($sformatf("stream_res_%0d", got), result, vr[got]);
                chk($sformatf("stream_flg_%0d", got), 32'(flags), 32'(vf[got]));
                got++;
            end
            held_v   = out_valid && !out_ready;
            held_res = result;
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                acc++;
            end
            cyc++;
        end
        chk("stream_count", 32'(got), 32'd8);
        chk("stream_latency", 32'(first_ov - first_acc), 32'd3);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1 chk("stream_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with beats in flight
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1; drive(i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1 chk("midrst_no_stale", 32'(out_valid), 32'd0);
        end

        run_op(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 add/subtract unit; successor to the single-precision multi-cycle fp_adder.
- Accepts one operation per cycle through a valid/ready handshake, with backpressure.
- Supports arbitrary exponent/mantissa widths, four rounding modes, full subnormal handling and IEEE exception flags.
- Sits in the FP execution cluster, driven by the issue stage and drained by writeback.

Parameters:
- EXP_W, 8, exponent field width (3..15).
- MAN_W, 23, stored fraction width (2..52); total width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- op_a  in  W  operand A.
- op_b  in  W  operand B.
- op_sub  in  1  1: A-B, 0: A+B.
- round_mode  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (-inf).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  rounded sum.
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}; divzero is always 0.

Behaviour:
- The clock is clk; reset rst is asynchronous and active-high. On reset, all stage valids clear, out_valid=0, result=0 and flags=0. in_ready is 1 once reset is released.
- Reset asserted mid-operation discards all in-flight beats; no partial result may appear after reset.
- Pipeline has 3 register stages; latency is exactly 3 cycles from the accepted beat to out_valid when there is no stall.
  - S1: unpack; classify zero/subnormal/normal/inf/NaN; apply op_sub to B's sign; swap so |A|>=|B|; align B with guard, round and sticky bits (sticky ORs all shifted-out bits; shift saturates at MAN_W+3).
  - S2: magnitude add/subtract; leading-zero count; normalise. Left shift is limited so the exponent does not go below 1; the result then becomes subnormal.
  - S3: round per round_mode, handle mantissa carry-out, overflow check, pack, and register result/flags.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - Global stall: in_ready = !(out_valid && !out_ready). While stalled, all stages hold, and result/flags stay stable.
  - Bubbles propagate; there is no compaction.
- Special cases:
  - Any NaN operand gives canonical quiet NaN (sign 0, exp all-ones, fraction MSB 1, rest 0). Invalid is set only if an input NaN is signalling.
  - inf - inf (effective) gives canonical NaN with invalid=1.
  - inf op finite gives that inf; flags 0.
  - Exact zero sum of opposite-sign operands gives +0, except in RDN, which gives -0.
  - (+0)+(+0) gives +0 and (-0)+(-0) gives -0.
- Overflow (exponent above max after rounding) sets overflow and inexact.
  - Result is inf for RNE.
  - Result is inf for RUP if positive and for RDN if negative; otherwise it is max finite.
  - RTZ always gives max finite.
- Underflow is set when the result is tiny after rounding and inexact. Inexact is set when any of guard/round/sticky is nonzero.

Optional Feature:
- Macro FP_ADDSUB_FTZ_EN.
- Defined:
  - Subnormal inputs are treated as signed zero in S1.
  - Subnormal results are flushed to signed zero with underflow=1 and inexact=1.
- Undefined: full gradual-underflow behaviour as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package fp_pkg holds:
  - the round-mode localparams (RM_RNE, RM_RTZ, RM_RUP, RM_RDN);
  - the flag bit indices (FLG_NV, FLG_DZ, FLG_OF, FLG_UF, FLG_NX);
  - the operand-class enum;
  - a function computing W from EXP_W/MAN_W.
- Sub-module fp_lzc (parametrised leading-zero counter) is instantiated in S2.

Test Plan (default EXP_W=8, MAN_W=23):
- 41A60000 + 40100000, RNE -> 41B80000, flags 00000. 41020000 - 41040000 -> BE000000.
- 7F800000 + FF800000 -> 7FC00000 with invalid; 7F800000 + 7F800000 -> 7F800000, flags 0.
- 3F800000 + 33800000 (1 + 2^-24): RNE -> 3F800000 with inexact; RUP -> 3F800001 with inexact.
- 7F7FFFFF + 7F7FFFFF: RNE -> 7F800000 with overflow+inexact; RTZ -> 7F7FFFFF with overflow+inexact.
  - 00000002 + 00000002 -> 00000004, flags 0.
  - 3F800000 - 3F800000: RNE -> 00000000; RDN -> 80000000.
- Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1...:
  - results appear in order with no loss or duplication;
  - result is held stable while stalled;
  - out_valid rises 3 cycles after the first accept.
  - Assert rst mid-stream: out_valid drops immediately and no stale beat emerges.
